// File: rtl/ias_alu_pkg.sv
// Shared constants and FSM encoding for the IAS ALU word adder.
package ias_alu_pkg;

  localparam int WORD_W  = 40;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = WORD_W / SLICE_W;
  localparam int IDX_W   = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice.sv
// W-bit combinational ripple adder; the one arithmetic slice reused for every byte step.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;
  assign cout = c[W];

  for (genvar i = 0; i < W; i++) begin : g_cell
    full_adder_cell u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

endmodule

// File: rtl/full_adder_cell.sv
// One-bit full adder, the basic cell of the shared slice adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ias_word_adder_seq.sv
// Byte-serial 40-bit add/subtract: one SLICE_W-bit step per clock, LSB slice first,
// carry held in a register between steps.
module ias_word_adder_seq #(
  parameter int WORD_W  = ias_alu_pkg::WORD_W,
  parameter int SLICE_W = ias_alu_pkg::SLICE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [WORD_W-1:0]   op_a,
  input  logic [WORD_W-1:0]   op_b,
  output logic                busy,
  output logic                done,
  output logic [WORD_W-1:0]   result,
  output logic                carry_out,
  output logic                overflow,
  output ias_alu_pkg::state_e dbg_state
);

  localparam int NSLICE = WORD_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  import ias_alu_pkg::*;

  // Handshake: start is sampled only in IDLE (operands and sub captured on that edge);
  // busy is high in RUN and DONE; done pulses for the single DONE cycle, after which
  // result/carry_out/overflow hold until the next operation overwrites them.

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q;
  logic                           carry_q;
  logic [NSLICE-1:0][SLICE_W-1:0] a_q, b_q, res_q;
  logic [SLICE_W-1:0]             sl_sum;
  logic                           sl_cout;
  logic                           last_step;

  adder_slice #(.W(SLICE_W)) u_slice (
    .a   (a_q[idx_q]),
    .b   (b_q[idx_q]),
    .cin (carry_q),
    .sum (sl_sum),
    .cout(sl_cout)
  );

  assign last_step = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state_q == IDLE && start) begin
      // Subtract as A + ~B + 1: the +1 enters as the initial carry.
      a_q     <= op_a;
      b_q     <= sub ? ~op_b : op_b;
      carry_q <= sub;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      res_q[idx_q] <= sl_sum;
      carry_q      <= sl_cout;
      idx_q        <= idx_q + 1'b1;
      if (last_step) begin
        carry_out <= sl_cout;
        overflow  <= (a_q[NSLICE-1][SLICE_W-1] == b_q[NSLICE-1][SLICE_W-1]) &&
                     (sl_sum[SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ias_word_adder_seq.md
Name: ias_word_adder_seq

Overview:
- Byte-serial sequencer that performs one 40-bit IAS-word add or subtract through a single 8-bit adder slice.
- Processes one slice per clock, LSB slice first, with a registered carry between slices.
- Serves the IAS ALU as its AC ± MQ/memory-operand adder in place of a full-width ripple chain.
- Start/done handshake toward the control unit.

Parameters:
- WORD_W, 40, operand/result width; must be an integer multiple of SLICE_W.
- SLICE_W, 8, width of the shared adder slice.
- NSLICE, WORD_W/SLICE_W (5), number of slice steps; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- op_a  input  WORD_W  operand A; sampled with start.
- op_b  input  WORD_W  operand B; sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result/flags valid from this cycle onward.
- result  output  WORD_W  sum/difference, two's complement.
- carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE; busy, done, result, carry_out, overflow, slice index and internal carry all 0. Reset asserted mid-operation aborts the operation immediately with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - latch A=op_a and B'=(sub ? ~op_b : op_b);
  - carry reg = sub; idx = 0; go to RUN.
  - result and flags keep their previous values until overwritten slice by slice.
- RUN, each edge:
  - slice idx computes A[idx]+B'[idx]+carry;
  - write the slice sum into result[idx*SLICE_W +: SLICE_W];
  - carry = slice cout; idx++.
  - On the edge that processes idx = NSLICE-1: carry_out = slice cout; overflow = (A msb == B' msb) && (sum msb != A msb); go to DONE.
- DONE: done=1 for exactly one cycle, then back to IDLE. busy remains high in DONE.
- Latency: start sampled at edge k → done high in the cycle after edge k+NSLICE (6 cycles after start for defaults). Throughput is one operation per NSLICE+2 cycles.
- start while busy (RUN or DONE) is ignored; no queueing. Operand changes after the start edge have no effect.
- start held high continuously: a new operation is accepted at the first IDLE cycle after done.
- Width rules: all arithmetic is modulo 2^WORD_W. No sign-magnitude conversion; the control unit handles IAS sign-magnitude outside this block.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package ias_alu_pkg:
  - WORD_W, SLICE_W constants;
  - state enum {IDLE, RUN, DONE};
  - slice-index width constant $clog2(NSLICE).
- One sub-module, adder_slice: SLICE_W-bit combinational ripple adder built from the existing full_adder_cell. Inputs a, b, cin; outputs sum, cout. Instantiated once, with operands muxed by idx.

Test Plan:
- Add 0x00000000FF + 0x0000000001 → result 0x0000000100, carry_out 0, overflow 0; done exactly 6 cycles after start, busy high for those cycles.
- Add 0xFFFFFFFFFF + 0x0000000001 (carry ripples through all 5 slices) → result 0x0000000000, carry_out 1, overflow 0.
- Subtract 0x0000000005 - 0x0000000007 → result 0xFFFFFFFFFE, carry_out 0 (borrow), overflow 0. Subtract 7-5 → 0x0000000002, carry_out 1.
- Add 0x7FFFFFFFFF + 0x0000000001 → result 0x8000000000, overflow 1. Subtract 0x8000000000 - 0x0000000001 → 0x7FFFFFFFFF, overflow 1.
- Pulse start with new operands during RUN and during DONE → ignored; result is that of the first operation; exactly one done pulse.
- Assert rst_n=0 in the 3rd RUN cycle → all outputs 0 asynchronously, no done. After release, add 3+4 → result 0x0000000007, done 6 cycles later.
